control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 206 ++++++++++++++++++++
 tb/tb_control_unit.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multicycle datapath controller: 16-state FSM with outputs decoded from the state register.
// Optional exception support (invalid opcode/funct, arithmetic overflow) is enabled by CTRL_OVERFLOW_EXC_EN.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  output logic       pc_load,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_load,
  output logic       mdr_load,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [2:0] mem_to_reg,
  output logic       regA_load,
  output logic       regB_load,
  output logic       alu_srcA,
  output logic [1:0] alu_srcB,
  output logic [2:0] alu_op,
  output logic       aluout_load,
  output logic       epc_load,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RESET       = 4'd0,
    S_FETCH       = 4'd1,
    S_FETCH_WAIT  = 4'd2,
    S_DECODE      = 4'd3,
    S_EXEC_R      = 4'd4,
    S_WB_R        = 4'd5,
    S_EXEC_I      = 4'd6,
    S_WB_I        = 4'd7,
    S_ADDR        = 4'd8,
    S_MEM_RD      = 4'd9,
    S_MEM_RD_WAIT = 4'd10,
    S_WB_LW       = 4'd11,
    S_MEM_WR      = 4'd12,
    S_BRANCH      = 4'd13,
    S_JUMP        = 4'd14,
    S_EXC         = 4'd15
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b110;

`ifdef CTRL_OVERFLOW_EXC_EN
  localparam logic EXC_EN       = 1'b1;
  localparam state_t BAD_TARGET = S_EXC;
`else
  localparam logic EXC_EN       = 1'b0;
  localparam state_t BAD_TARGET = S_FETCH;
`endif

  state_t state_q;
  state_t state_d;
  logic   ovf_q;
  logic [2:0] r_op;
  logic       r_valid;
  logic       r_arith;

  assign state = state_q;

  // R-type function decode; r_arith marks the ops whose overflow is meaningful.
  always_comb begin
    r_op    = 3'b000;
    r_valid = 1'b1;
    r_arith = 1'b0;
    case (funct)
      6'h20: begin r_op = ALU_ADD; r_arith = 1'b1; end
      6'h22: begin r_op = ALU_SUB; r_arith = 1'b1; end
      6'h24: r_op = ALU_AND;
      6'h26: r_op = ALU_XOR;
      default: r_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_FETCH:  ovf_q <= 1'b0;
        S_EXEC_R: ovf_q <= r_arith & alu_overflow;
        S_EXEC_I: ovf_q <= alu_overflow;
        default:  ovf_q <= ovf_q;
      endcase
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_RESET:      state_d = S_FETCH;
      S_FETCH:      state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h00:        state_d = S_EXEC_R;
          6'h08:        state_d = S_EXEC_I;
          6'h23, 6'h2B: state_d = S_ADDR;
          6'h04, 6'h05: state_d = S_BRANCH;
          6'h02:        state_d = S_JUMP;
          default:      state_d = BAD_TARGET;
        endcase
      end
      S_EXEC_R:      state_d = r_valid ? S_WB_R : BAD_TARGET;
      S_WB_R:        state_d = (EXC_EN && ovf_q) ? S_EXC : S_FETCH;
      S_EXEC_I:      state_d = S_WB_I;
      S_WB_I:        state_d = (EXC_EN && ovf_q) ? S_EXC : S_FETCH;
      S_ADDR:        state_d = (opcode == 6'h2B) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:      state_d = S_MEM_RD_WAIT;
      S_MEM_RD_WAIT: state_d = S_WB_LW;
      default:       state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_load     = 1'b0;
    pc_src      = 2'b00;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_load     = 1'b0;
    mdr_load    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 2'b00;
    mem_to_reg  = 3'b000;
    regA_load   = 1'b0;
    regB_load   = 1'b0;
    alu_srcA    = 1'b0;
    alu_srcB    = 2'b00;
    alu_op      = 3'b000;
    aluout_load = 1'b0;
    epc_load    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_srcB = 2'b01;
        alu_op   = ALU_ADD;
        pc_load  = 1'b1;
      end
      S_FETCH_WAIT: ir_load = 1'b1;
      S_DECODE: begin
        regA_load   = 1'b1;
        regB_load   = 1'b1;
        alu_srcB    = 2'b11;
        alu_op      = ALU_ADD;
        aluout_load = 1'b1;
      end
      S_EXEC_R: begin
        alu_srcA    = 1'b1;
        alu_op      = r_op;
        aluout_load = 1'b1;
      end
      S_WB_R: begin
        reg_dst   = 2'b01;
        reg_write = ~(EXC_EN & ovf_q);
      end
      S_EXEC_I, S_ADDR: begin
        alu_srcA    = 1'b1;
        alu_srcB    = 2'b10;
        alu_op      = ALU_ADD;
        aluout_load = 1'b1;
      end
      S_WB_I: reg_write = ~(EXC_EN & ovf_q);
      S_MEM_RD: iord = 1'b1;
      S_MEM_RD_WAIT: begin
        iord     = 1'b1;
        mdr_load = 1'b1;
      end
      S_WB_LW: begin
        mem_to_reg = 3'b001;
        reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      // beq takes the branch on zero, bne on non-zero.
      S_BRANCH: begin
        alu_srcA = 1'b1;
        alu_op   = ALU_SUB;
        pc_src   = 2'b01;
        pc_load  = (opcode == 6'h04) ? alu_zero : ~alu_zero;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_load = 1'b1;
      end
      S_EXC: begin
        epc_load = EXC_EN;
        pc_src   = EXC_EN ? 2'b11 : 2'b00;
        pc_load  = EXC_EN;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-cycle expected output vectors queued per instruction and checked at negedge.
module tb_control_unit;

  localparam int W = 27;

`ifdef CTRL_OVERFLOW_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       alu_overflow;
  logic       pc_load;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_write;
  logic       ir_load;
  logic       mdr_load;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [2:0] mem_to_reg;
  logic       regA_load;
  logic       regB_load;
  logic       alu_srcA;
  logic [1:0] alu_srcB;
  logic [2:0] alu_op;
  logic       aluout_load;
  logic       epc_load;
  logic [3:0] state;

  logic [W-1:0] exp_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  string        cur_test = "none";

  control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .pc_load(pc_load), .pc_src(pc_src), .iord(iord), .mem_write(mem_write),
    .ir_load(ir_load), .mdr_load(mdr_load), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .regA_load(regA_load),
    .regB_load(regB_load), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
    .alu_op(alu_op), .aluout_load(aluout_load), .epc_load(epc_load),
    .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [W-1:0] observe();
    return {state, pc_load, pc_src, iord, mem_write, ir_load, mdr_load, reg_write,
            reg_dst, mem_to_reg, regA_load, regB_load, alu_srcA, alu_srcB, alu_op,
            aluout_load, epc_load};
  endfunction

  function automatic logic [W-1:0] ev(
    input logic [3:0] st, input logic pcl, input logic [1:0] pcs,
    input logic io, input logic mw, input logic irl, input logic mdl, input logic rw,
    input logic [1:0] rd, input logic [2:0] m2r, input logic al, input logic bl,
    input logic sa, input logic [1:0] sb, input logic [2:0] op,
    input logic aol, input logic epc);
    return {st, pcl, pcs, io, mw, irl, mdl, rw, rd, m2r, al, bl, sa, sb, op, aol, epc};
  endfunction

  // Expected per-state output vectors, written from the state descriptions.
  function automatic logic [W-1:0] e_reset();
    return '0;
  endfunction
  function automatic logic [W-1:0] e_fetch();
    return ev(4'd1, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 2'b01, 3'b001, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_fwait();
    return ev(4'd2, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_decode();
    return ev(4'd3, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 1, 0, 2'b11, 3'b001, 1, 0);
  endfunction
  function automatic logic [W-1:0] e_exec_r(input logic [2:0] op);
    return ev(4'd4, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 1, 2'b00, op, 1, 0);
  endfunction
  function automatic logic [W-1:0] e_wb_r(input logic rw);
    return ev(4'd5, 0, 2'b00, 0, 0, 0, 0, rw, 2'b01, 3'b000, 0, 0, 0, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_exec_i();
    return ev(4'd6, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 1, 2'b10, 3'b001, 1, 0);
  endfunction
  function automatic logic [W-1:0] e_wb_i(input logic rw);
    return ev(4'd7, 0, 2'b00, 0, 0, 0, 0, rw, 2'b00, 3'b000, 0, 0, 0, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_addr();
    return ev(4'd8, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 1, 2'b10, 3'b001, 1, 0);
  endfunction
  function automatic logic [W-1:0] e_mem_rd();
    return ev(4'd9, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_mem_rd_wait();
    return ev(4'd10, 0, 2'b00, 1, 0, 0, 1, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_wb_lw();
    return ev(4'd11, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 3'b001, 0, 0, 0, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_mem_wr();
    return ev(4'd12, 0, 2'b00, 1, 1, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_branch(input logic pcl);
    return ev(4'd13, pcl, 2'b01, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 1, 2'b00, 3'b010, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_jump();
    return ev(4'd14, 1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 3'b000, 0, 0);
  endfunction
  function automatic logic [W-1:0] e_exc();
    return ev(4'd15, 1, 2'b11, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 2'b00, 3'b000, 0, 1);
  endfunction

  // Reference sequence for one instruction, starting with its FETCH cycle.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input logic o);
    logic [2:0] aop;
    logic       arith;
    logic       fn_ok;
    exp_q.push_back(e_fetch());
    exp_q.push_back(e_fwait());
    exp_q.push_back(e_decode());
    case (op)
      6'h00: begin
        fn_ok = 1'b1;
        arith = 1'b0;
        case (fn)
          6'h20: begin aop = 3'b001; arith = 1'b1; end
          6'h22: begin aop = 3'b010; arith = 1'b1; end
          6'h24: aop = 3'b011;
          6'h26: aop = 3'b110;
          default: begin aop = 3'b000; fn_ok = 1'b0; end
        endcase
        exp_q.push_back(e_exec_r(aop));
        if (!fn_ok) begin
          if (EXC_EN) exp_q.push_back(e_exc());
        end else if (EXC_EN && arith && o) begin
          exp_q.push_back(e_wb_r(1'b0));
          exp_q.push_back(e_exc());
        end else begin
          exp_q.push_back(e_wb_r(1'b1));
        end
      end
      6'h08: begin
        exp_q.push_back(e_exec_i());
        if (EXC_EN && o) begin
          exp_q.push_back(e_wb_i(1'b0));
          exp_q.push_back(e_exc());
        end else begin
          exp_q.push_back(e_wb_i(1'b1));
        end
      end
      6'h23: begin
        exp_q.push_back(e_addr());
        exp_q.push_back(e_mem_rd());
        exp_q.push_back(e_mem_rd_wait());
        exp_q.push_back(e_wb_lw());
      end
      6'h2B: begin
        exp_q.push_back(e_addr());
        exp_q.push_back(e_mem_wr());
      end
      6'h04: exp_q.push_back(e_branch(z));
      6'h05: exp_q.push_back(e_branch(~z));
      6'h02: exp_q.push_back(e_jump());
      default: if (EXC_EN) exp_q.push_back(e_exc());
    endcase
  endtask

  // scoreboard: one expected vector per cycle, compared at the falling edge
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] want;
    if (exp_q.size() > 0) begin
      got  = observe();
      want = exp_q.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s: state got %0d expected %0d, outputs got %h expected %h",
                 cur_test, got[W-1 -: 4], want[W-1 -: 4], got, want);
      end
    end
  end

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 64) begin
      @(negedge clk);
      #2;
      guard++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL %s: queue not drained, %0d entries left, required 0", cur_test, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Starts in the cycle before FETCH; inputs change after FETCH is sampled.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic o);
    push_instr(op, fn, z, o);
    @(negedge clk);
    #1;
    opcode = op; funct = fn; alu_zero = z; alu_overflow = o;
    drain();
  endtask

  task automatic test_reset();
    cur_test = "reset";
    rst = 1'b1;
    opcode = 6'h02; funct = 6'h00; alu_zero = 1'b0; alu_overflow = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (observe() !== e_reset()) begin
      miscompares++;
      $display("FAIL reset_value: outputs got %h expected %h", observe(), e_reset());
    end
    #1;
    rst = 1'b0;
    exp_q.push_back(e_reset());
    exp_q.push_back(e_fetch());
    exp_q.push_back(e_fwait());
    exp_q.push_back(e_decode());
    exp_q.push_back(e_jump());
    drain();
  endtask

  task automatic test_rtype();
    cur_test = "rtype";
    run_instr(6'h00, 6'h22, 1'($urandom_range(0, 1)), 1'b0);
    run_instr(6'h00, 6'h20, 1'($urandom_range(0, 1)), 1'b0);
    run_instr(6'h00, 6'h24, 1'($urandom_range(0, 1)), 1'b0);
    run_instr(6'h00, 6'h26, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic test_load_store();
    cur_test = "load_store";
    run_instr(6'h23, 6'h00, 1'b0, 1'b0);
    run_instr(6'h2B, 6'h11, 1'b1, 1'b0);
  endtask

  task automatic test_branch();
    cur_test = "branch";
    run_instr(6'h05, 6'h00, 1'b0, 1'b0);
    run_instr(6'h04, 6'h00, 1'b0, 1'b0);
    run_instr(6'h04, 6'h00, 1'b1, 1'b0);
    run_instr(6'h05, 6'h00, 1'b1, 1'b0);
    cur_test = "jump";
    run_instr(6'h02, 6'h3F, 1'b1, 1'b1);
  endtask

  task automatic test_overflow();
    cur_test = "overflow";
    run_instr(6'h08, 6'h00, 1'b0, 1'b1);
    run_instr(6'h08, 6'h00, 1'b0, 1'b0);
    run_instr(6'h00, 6'h20, 1'b0, 1'b1);
    run_instr(6'h00, 6'h22, 1'b0, 1'b1);
    run_instr(6'h00, 6'h24, 1'b0, 1'b1);
    run_instr(6'h00, 6'h26, 1'b0, 1'b1);
  endtask

  task automatic test_invalid();
    cur_test = "invalid";
    run_instr(6'h3F, 6'h00, 1'b0, 1'b0);
    run_instr(6'h00, 6'h3F, 1'b0, 1'b0);
    run_instr(6'h08, 6'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    cur_test = "reset_mid_write";
    run_instr(6'h2B, 6'h00, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    vectors++;
    if (mem_write !== 1'b0 || state !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_mid_write: mem_write got %b state got %0d, required 0 and 0",
               mem_write, state);
    end
    vectors++;
    if (observe() !== e_reset()) begin
      miscompares++;
      $display("FAIL reset_mid_write_outputs: got %h expected %h", observe(), e_reset());
    end
    @(posedge clk);
    #2;
    opcode = 6'h08; funct = 6'h00; alu_overflow = 1'b0;
    rst = 1'b0;
    exp_q.push_back(e_reset());
    exp_q.push_back(e_fetch());
    exp_q.push_back(e_fwait());
    exp_q.push_back(e_decode());
    exp_q.push_back(e_exec_i());
    exp_q.push_back(e_wb_i(1'b1));
    drain();
  endtask

  task automatic test_back_to_back();
    logic [5:0] op_tab[11];
    logic [5:0] fn_tab[11];
    int k;
    cur_test = "back_to_back";
    op_tab = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h26, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 10);
      run_instr(op_tab[k], fn_tab[k], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_store();
    test_branch();
    test_overflow();
    test_invalid();
    test_reset_mid_write();
    test_back_to_back();
    cur_test = "final_fetch";
    exp_q.push_back(e_fetch());
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
